// File: rtl/cricket_score_entry.sv
// Button-driven score entry for a two-innings cricket game: conditions the push-buttons
// and sequences INN1 -> BREAK -> INN2 -> DONE. Optional build macro: EXTRAS_EN (adds btn_extra).
module cricket_score_entry #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int MAX_BALLS       = 12,
  parameter int MAX_WICKETS     = 10
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       btn_ball,
  input  logic       btn_next,
`ifdef EXTRAS_EN
  input  logic       btn_extra,
`endif
  input  logic [2:0] sw_runs,
  input  logic       sw_out,
  output logic [7:0] binaryRuns,
  output logic [3:0] binaryWickets,
  output logic       inningOver,
  output logic       gameOver,
  output logic       winner
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX      = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    WICKET_LIMIT = 4'(MAX_WICKETS);
  localparam logic [7:0]    BALL_LIMIT   = 8'(MAX_BALLS);

`ifdef EXTRAS_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  typedef enum logic [1:0] {
    INN1  = 2'd0,
    BREAK = 2'd1,
    INN2  = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_pulse;

`ifdef EXTRAS_EN
  assign btn_raw = {btn_extra, btn_next, btn_ball};
`else
  assign btn_raw = {btn_next, btn_ball};
`endif

  // Each conditioned button yields a single-cycle strobe; strobes carry no handshake
  // and are consumed or dropped in the cycle they appear, depending on the game state.
  // A button is armed only after its level has been seen settled low, so a press that
  // is still held when reset releases cannot fire until it is released and pressed again.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_btn
      logic          sync_q1;
      logic          sync_q2;
      logic          level_q;
      logic          stable;
      logic          armed;
      logic          pulse_q;
      logic [CW-1:0] cnt;

      always_ff @(posedge clk_fpga or posedge reset) begin
        if (reset) begin
          sync_q1 <= 1'b0;
          sync_q2 <= 1'b0;
          level_q <= 1'b0;
          stable  <= 1'b0;
          armed   <= 1'b0;
          pulse_q <= 1'b0;
          cnt     <= '0;
        end else begin
          sync_q1 <= btn_raw[gi];
          sync_q2 <= sync_q1;
          level_q <= sync_q2;
          pulse_q <= 1'b0;
          if (sync_q2 != level_q) begin
            cnt <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
          if (cnt == CNT_MAX) begin
            stable <= level_q;
            if (!level_q) begin
              armed <= 1'b1;
            end
            if (level_q && !stable && armed) begin
              pulse_q <= 1'b1;
            end
          end
        end
      end

      assign btn_pulse[gi] = pulse_q;
    end
  endgenerate

  logic ball_p;
  logic next_p;
  logic extra_p;

  assign ball_p = btn_pulse[0];
  assign next_p = btn_pulse[1];
`ifdef EXTRAS_EN
  assign extra_p = btn_pulse[2];
`else
  assign extra_p = 1'b0;
`endif

  state_t     state;
  logic [7:0] runs;
  logic [3:0] wickets;
  logic [7:0] balls;
  logic [7:0] runs1;
  logic       inning_over_q;
  logic       game_over_q;
  logic       winner_q;

  logic       in_play;
  logic       ball_act;
  logic       extra_act;
  logic [2:0] ball_runs;
  logic [3:0] run_gain;
  logic [8:0] runs_sum;
  logic [7:0] runs_nx;
  logic [3:0] wickets_nx;
  logic [7:0] balls_nx;
  logic       innings_end;
  logic       chase_won;

  assign in_play   = (state == INN1) || (state == INN2);
  assign ball_act  = ball_p && in_play;
  assign extra_act = extra_p && in_play;

  // Post-delivery values; the state decision below looks at these, so the
  // innings-ending ball is both counted and acted on in the same cycle.
  always_comb begin
    ball_runs = (sw_runs == 3'd7) ? 3'd6 : sw_runs;
    run_gain  = 4'd0;
    if (ball_act && !sw_out) begin
      run_gain = {1'b0, ball_runs};
    end
    if (extra_act) begin
      run_gain = run_gain + 4'd1;
    end
    runs_sum    = {1'b0, runs} + {5'd0, run_gain};
    runs_nx     = runs_sum[8] ? 8'hFF : runs_sum[7:0];
    wickets_nx  = wickets + {3'd0, (ball_act & sw_out)};
    balls_nx    = balls + {7'd0, ball_act};
    innings_end = (wickets_nx == WICKET_LIMIT) || (balls_nx == BALL_LIMIT);
    chase_won   = (runs_nx > runs1);
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state         <= INN1;
      runs          <= 8'd0;
      wickets       <= 4'd0;
      balls         <= 8'd0;
      runs1         <= 8'd0;
      inning_over_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      case (state)
        INN1: begin
          if (ball_act || extra_act) begin
            runs    <= runs_nx;
            wickets <= wickets_nx;
            balls   <= balls_nx;
            if (innings_end) begin
              state         <= BREAK;
              runs1         <= runs_nx;
              inning_over_q <= 1'b1;
            end
          end
        end
        BREAK: begin
          if (next_p) begin
            state         <= INN2;
            runs          <= 8'd0;
            wickets       <= 4'd0;
            balls         <= 8'd0;
            inning_over_q <= 1'b0;
          end
        end
        INN2: begin
          if (ball_act || extra_act) begin
            runs    <= runs_nx;
            wickets <= wickets_nx;
            balls   <= balls_nx;
            if (chase_won || innings_end) begin
              state       <= DONE;
              game_over_q <= 1'b1;
              winner_q    <= chase_won;
            end
          end
        end
        DONE: begin
          if (next_p) begin
            state         <= INN1;
            runs          <= 8'd0;
            wickets       <= 4'd0;
            balls         <= 8'd0;
            runs1         <= 8'd0;
            inning_over_q <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
          end
        end
        default: state <= INN1;
      endcase
    end
  end

  assign binaryRuns    = runs;
  assign binaryWickets = wickets;
  assign inningOver    = inning_over_q;
  assign gameOver      = game_over_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_cricket_score_entry.sv
// Directed bench for cricket_score_entry with small debounce/innings limits, plus a
// second instance with MAX_BALLS=255 to reach run saturation.
module tb_cricket_score_entry;

  localparam int D  = 4;
  localparam int MB = 6;
  localparam int MW = 2;

  logic       clk_fpga = 1'b0;
  logic       reset;
  logic       btn_ball, btn_next, btn_ball_s, btn_next_s;
  logic [2:0] sw_runs;
  logic       sw_out;
`ifdef EXTRAS_EN
  logic       btn_extra, btn_extra_s;
`endif

  logic [7:0] binaryRuns, runs_s;
  logic [3:0] binaryWickets, wickets_s;
  logic       inningOver, gameOver, winner;
  logic       inning_over_s, game_over_s, winner_s;

  int checks = 0;
  int errors = 0;

  always #5 clk_fpga = ~clk_fpga;

  cricket_score_entry #(.DEBOUNCE_CYCLES(D), .MAX_BALLS(MB), .MAX_WICKETS(MW)) dut (
    .clk_fpga      (clk_fpga),
    .reset         (reset),
    .btn_ball      (btn_ball),
    .btn_next      (btn_next),
`ifdef EXTRAS_EN
    .btn_extra     (btn_extra),
`endif
    .sw_runs       (sw_runs),
    .sw_out        (sw_out),
    .binaryRuns    (binaryRuns),
    .binaryWickets (binaryWickets),
    .inningOver    (inningOver),
    .gameOver      (gameOver),
    .winner        (winner)
  );

  cricket_score_entry #(.DEBOUNCE_CYCLES(D), .MAX_BALLS(255), .MAX_WICKETS(MW)) dut_sat (
    .clk_fpga      (clk_fpga),
    .reset         (reset),
    .btn_ball      (btn_ball_s),
    .btn_next      (btn_next_s),
`ifdef EXTRAS_EN
    .btn_extra     (btn_extra_s),
`endif
    .sw_runs       (sw_runs),
    .sw_out        (sw_out),
    .binaryRuns    (runs_s),
    .binaryWickets (wickets_s),
    .inningOver    (inning_over_s),
    .gameOver      (game_over_s),
    .winner        (winner_s)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input int r, input int w, input int io,
                             input int go, input int win);
    check_val({tag, ".runs"}, int'(binaryRuns), r);
    check_val({tag, ".wickets"}, int'(binaryWickets), w);
    check_val({tag, ".inningOver"}, int'(inningOver), io);
    check_val({tag, ".gameOver"}, int'(gameOver), go);
    check_val({tag, ".winner"}, int'(winner), win);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_fpga);
  endtask

  task automatic release_all();
    btn_ball   = 1'b0;
    btn_next   = 1'b0;
    btn_ball_s = 1'b0;
    btn_next_s = 1'b0;
`ifdef EXTRAS_EN
    btn_extra   = 1'b0;
    btn_extra_s = 1'b0;
`endif
  endtask

  // Clean press: held well past the debounce window, then released long enough to re-arm.
  task automatic press(input logic b, input logic n, input logic e, input logic s,
                       input logic [2:0] r, input logic o);
    sw_runs = r;
    sw_out  = o;
    if (s) begin
      btn_ball_s = 1'b1;
    end else begin
      btn_ball = b;
      btn_next = n;
`ifdef EXTRAS_EN
      btn_extra = e;
`endif
    end
    tick(12);
    release_all();
    tick(12);
  endtask

  task automatic ball(input logic [2:0] r, input logic o);
    press(1'b1, 1'b0, 1'b0, 1'b0, r, o);
  endtask

  task automatic next_btn();
    press(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(10);
  endtask

  initial begin
    reset   = 1'b1;
    sw_runs = 3'd0;
    sw_out  = 1'b0;
    release_all();
    tick(3);
    expect_outs("reset", 0, 0, 0, 0, 0);
    check_val("reset.sat_runs", int'(runs_s), 0);
    reset = 1'b0;
    tick(10);

    // Glitches shorter than the debounce window, then a real hold.
    sw_runs  = 3'd4;
    btn_ball = 1'b1; tick(1);
    btn_ball = 1'b0; tick(2);
    btn_ball = 1'b1; tick(2);
    btn_ball = 1'b0; tick(2);
    btn_ball = 1'b1; tick(1);
    btn_ball = 1'b0; tick(10);
    check_val("glitch.runs", int'(binaryRuns), 0);
    btn_ball = 1'b1; tick(20);
    btn_ball = 1'b0; tick(12);
    expect_outs("hold", 4, 0, 0, 0, 0);

    // Innings 1 ended by balls; ball ignored in BREAK.
    do_reset();
    for (int i = 0; i < 5; i++) ball(3'd1, 1'b0);
    expect_outs("inn1.b5", 5, 0, 0, 0, 0);
    ball(3'd1, 1'b0);
    expect_outs("inn1.b6", 6, 0, 1, 0, 0);
    ball(3'd3, 1'b0);
    expect_outs("break.ball", 6, 0, 1, 0, 0);

    // Chase succeeds on the second ball; ball ignored in DONE; next restarts.
    next_btn();
    expect_outs("inn2.start", 0, 0, 0, 0, 0);
    ball(3'd6, 1'b0);
    expect_outs("chase.b1", 6, 0, 0, 0, 0);
    ball(3'd1, 1'b0);
    expect_outs("chase.b2", 7, 0, 0, 1, 1);
    ball(3'd2, 1'b0);
    expect_outs("done.ball", 7, 0, 0, 1, 1);
    next_btn();
    expect_outs("restart", 0, 0, 0, 0, 0);

    // Target 6, innings 2 all out for 0.
    for (int i = 0; i < 6; i++) ball(3'd1, 1'b0);
    next_btn();
    ball(3'd0, 1'b1);
    expect_outs("allout.w1", 0, 1, 0, 0, 0);
    ball(3'd0, 1'b1);
    expect_outs("allout.w2", 0, 2, 0, 1, 0);
    next_btn();

    // Target 6, innings 2 ties on the last ball: team 1 wins.
    for (int i = 0; i < 6; i++) ball(3'd1, 1'b0);
    next_btn();
    for (int i = 0; i < 5; i++) ball(3'd1, 1'b0);
    expect_outs("tie.b5", 5, 0, 0, 0, 0);
    ball(3'd1, 1'b0);
    expect_outs("tie.b6", 6, 0, 0, 1, 0);
    next_btn();

    // Clamp of 7, simultaneous ball+next in INN1, innings ended by wickets.
    ball(3'd7, 1'b0);
    expect_outs("clamp7", 6, 0, 0, 0, 0);
    press(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0);
    expect_outs("both.inn1", 8, 0, 0, 0, 0);
    ball(3'd5, 1'b1);
    expect_outs("out.runs_kept", 8, 1, 0, 0, 0);
    ball(3'd0, 1'b1);
    expect_outs("inn1.wkts", 8, 2, 1, 0, 0);
    next_btn();
    ball(3'd3, 1'b0);
    expect_outs("inn2.b1", 3, 0, 0, 0, 0);

    // Held ball fires once, then asynchronous reset while still held.
    sw_runs  = 3'd1;
    sw_out   = 1'b0;
    btn_ball = 1'b1;
    tick(12);
    check_val("held.runs", int'(binaryRuns), 4);
    reset = 1'b1;
    #1;
    check_val("async.runs", int'(binaryRuns), 0);
    check_val("async.wickets", int'(binaryWickets), 0);
    tick(2);
    reset = 1'b0;
    tick(20);
    expect_outs("held_after_reset", 0, 0, 0, 0, 0);
    btn_ball = 1'b0;
    tick(12);
    ball(3'd5, 1'b0);
    expect_outs("repress", 5, 0, 0, 0, 0);

`ifdef EXTRAS_EN
    // Extra with a ball: sw_runs + 1 and one ball; extra alone adds a run only.
    press(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
    expect_outs("extra+ball", 8, 0, 0, 0, 0);
    press(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    expect_outs("extra.only", 9, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) ball(3'd0, 1'b0);
    expect_outs("extra.b5", 9, 0, 0, 0, 0);
    ball(3'd0, 1'b0);
    expect_outs("extra.b6", 9, 0, 1, 0, 0);
`endif

    // Saturation on the 255-ball instance: 42 sixes = 252, then clamp at 255.
    for (int i = 0; i < 42; i++) press(1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
    check_val("sat.252", int'(runs_s), 252);
    press(1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
    check_val("sat.255", int'(runs_s), 255);
    press(1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0);
    check_val("sat.hold", int'(runs_s), 255);
    check_val("sat.inningOver", int'(inning_over_s), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
